// File: rtl/ntr_card.sv
// NTR game-card bus slave: decodes 8-byte host commands and answers 0x90 (Get Chip ID).
// Build option NTR_DUMMY_EDGE_EN: discard the first ntr_clk rise after card select.
`timescale 1ns/1ps

module ntr_pad_io (
    input  logic       dir_i,
    inout  wire  [7:0] pad_io,
    input  logic [7:0] out_i,
    output logic [7:0] in_o
);
    assign pad_io = dir_i ? 8'bzzzz_zzzz : out_i;
    assign in_o   = pad_io;
endmodule

module ntr_card_top #(
    parameter logic [31:0] CHIP_ID     = 32'h0000_3FC2,
    parameter int          ID_BYTES    = 4,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    inout  wire  [7:0] ntr_data,
    input  logic       ntr_clk,
    input  logic       ntr_cs1,
    output logic [3:0] led
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DUMMY = 3'd1,
        ST_CMD   = 3'd2,
        ST_RESP  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    localparam logic [3:0] ID_BYTES_C = 4'(ID_BYTES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] cmd_q, cmd_d;
    logic [7:0]  out_q, out_d;
    logic        dir_q, dir_d;
    logic        done_q, done_d;
    logic        unk_q, unk_d;
    logic        sel_q;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [7:0]             data_sync_q [SYNC_STAGES];
    logic                   clk_prev_q;

    logic [7:0]  pad_in;
    logic        clk_s, cs_s;
    logic [7:0]  data_s;
    logic        rise, fall;
    logic [31:0] id_shift;
    logic [7:0]  resp_byte;

    ntr_pad_io u_pad (
        .dir_i  (dir_q),
        .pad_io (ntr_data),
        .out_i  (out_q),
        .in_o   (pad_in)
    );

    // Clock and select synchronizers reset to the idle-high bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= '1;
            cs_sync_q  <= '1;
            clk_prev_q <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= 8'h00;
        end else begin
            clk_sync_q     <= {clk_sync_q[SYNC_STAGES-2:0], ntr_clk};
            cs_sync_q      <= {cs_sync_q[SYNC_STAGES-2:0], ntr_cs1};
            clk_prev_q     <= clk_s;
            data_sync_q[0] <= pad_in;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign rise   = clk_s & ~clk_prev_q;
    assign fall   = ~clk_s & clk_prev_q;

    always_comb begin
        id_shift  = CHIP_ID >> {cnt_q, 3'b000};
        resp_byte = (cnt_q < ID_BYTES_C) ? id_shift[7:0] : 8'hFF;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        out_d   = out_q;
        dir_d   = dir_q;
        done_d  = done_q;
        unk_d   = unk_q;
        if (cs_s) begin
            // Deselect wins over everything: release the bus, drop any partial command.
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            cmd_d   = 64'd0;
            out_d   = 8'h00;
            dir_d   = 1'b1;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = 4'd0;
`ifdef NTR_DUMMY_EDGE_EN
                    state_d = ST_DUMMY;
`else
                    state_d = ST_CMD;
`endif
                end
                ST_DUMMY: begin
                    if (rise) state_d = ST_CMD;
                end
                ST_CMD: begin
                    if (rise) begin
                        cmd_d = {cmd_q[55:0], data_s};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            done_d = 1'b1;
                            cnt_d  = 4'd0;
                            if (cmd_d[63:56] == 8'h90) begin
                                state_d = ST_RESP;
                            end else begin
                                unk_d   = 1'b1;
                                state_d = ST_WAIT;
                            end
                        end
                    end
                end
                ST_RESP: begin
                    if (fall) begin
                        out_d = resp_byte;
                        dir_d = 1'b0;
                        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                    end
                end
                ST_WAIT: begin
                    dir_d = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            cmd_q   <= 64'd0;
            out_q   <= 8'h00;
            dir_q   <= 1'b1;
            done_q  <= 1'b0;
            unk_q   <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            out_q   <= out_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            unk_q   <= unk_d;
            sel_q   <= ~cs_s;
        end
    end

    assign led = {unk_q, (state_q == ST_RESP), done_q, sel_q};
endmodule

// File: tb/tb_ntr_card_top.sv
// Directed bench for ntr_card_top: command/response vectors plus deselect and reset corner cases.
`timescale 1ns/1ps

module tb_ntr_card_top;
    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ntr_clk = 1'b1;
    logic       ntr_cs1 = 1'b1;
    logic       host_en = 1'b0;
    logic [7:0] host_val = 8'h00;
    wire  [7:0] ntr_data;
    logic [3:0] led;

    int n_checks = 0;
    int n_pass   = 0;

    assign ntr_data = host_en ? host_val : 8'bzzzz_zzzz;

    always #1 clk = ~clk;

    ntr_card_top dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ntr_data (ntr_data),
        .ntr_clk  (ntr_clk),
        .ntr_cs1  (ntr_cs1),
        .led      (led)
    );

    typedef struct {
        logic [63:0] cmd;
        logic        resp;
        logic [47:0] exp_bytes;
        logic [3:0]  led_sel;
        logic [3:0]  led_desel;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One host bus clock: change data on fall, sample just before the rise.
    task automatic ntr_cycle(input logic drive, input logic [7:0] dout, output logic [7:0] din);
        ntr_clk  = 1'b0;
        host_en  = drive;
        host_val = dout;
        #8;
        din = ntr_data;
        #2;
        ntr_clk = 1'b1;
        #10;
    endtask

    task automatic do_select();
        logic [7:0] d;
        ntr_cs1 = 1'b0;
        #10;
`ifdef NTR_DUMMY_EDGE_EN
        ntr_cycle(1'b0, 8'h00, d);
`endif
    endtask

    task automatic send_bytes(input logic [63:0] c, input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) ntr_cycle(1'b1, c[63-8*i -: 8], d);
    endtask

    task automatic do_deselect(input string name, input logic [3:0] exp_led);
        host_en = 1'b0;
        ntr_cs1 = 1'b1;
        #8;
        check({name, "_release"}, {7'd0, dut.dir_q}, 8'h01);
        check({name, "_led"}, {4'd0, led}, {4'd0, exp_led});
        #12;
    endtask

    initial begin
        logic [7:0] d;

        vecs[0] = '{64'h9000_0000_0000_0000, 1'b1, 48'hC23F_0000_FFFF, 4'b0111, 4'b0000};
        vecs[1] = '{64'hFF00_0000_0000_0001, 1'b0, 48'h0,              4'b1011, 4'b1000};
        vecs[2] = '{64'h9011_2233_4455_6677, 1'b1, 48'hC23F_0000_FFFF, 4'b1111, 4'b1000};
        vecs[3] = '{64'h0090_9090_9090_9090, 1'b0, 48'h0,              4'b1011, 4'b1000};

        #10;
        rst_n = 1'b1;
        #10;
        check("reset_led", {4'd0, led}, 8'h00);
        check("reset_release", {7'd0, dut.dir_q}, 8'h01);

        for (int v = 0; v < 4; v++) begin
            do_select();
            send_bytes(vecs[v].cmd, 8);
            for (int k = 0; k < 6; k++) begin
                ntr_cycle(1'b0, 8'h00, d);
                if (vecs[v].resp)
                    check($sformatf("v%0d_byte%0d", v, k), d, vecs[v].exp_bytes[47-8*k -: 8]);
                else
                    check($sformatf("v%0d_nodrive%0d", v, k), {7'd0, dut.dir_q}, 8'h01);
            end
            check($sformatf("v%0d_led_sel", v), {4'd0, led}, {4'd0, vecs[v].led_sel});
            do_deselect($sformatf("v%0d_desel", v), vecs[v].led_desel);
        end

        // Partial command then a clean reselect must not leak stale bytes or counts.
        do_select();
        send_bytes(64'h9012_3400_0000_0000, 3);
        check("partial_nodrive", {7'd0, dut.dir_q}, 8'h01);
        do_deselect("partial_desel", 4'b1000);
        do_select();
        send_bytes(64'h9000_0000_0000_0000, 8);
        ntr_cycle(1'b0, 8'h00, d);
        check("reselect_byte0", d, 8'hC2);
        ntr_cycle(1'b0, 8'h00, d);
        check("reselect_byte1", d, 8'h3F);
        check("reselect_led", {4'd0, led}, 8'h0F);
        ntr_cycle(1'b0, 8'h00, d);
        check("reselect_byte2", d, 8'h00);

        // Async reset while the card is actively driving.
        ntr_clk = 1'b0;
        #8;
        check("pre_reset_drive", {7'd0, dut.dir_q}, 8'h00);
        rst_n = 1'b0;
        #1;
        check("async_reset_release", {7'd0, dut.dir_q}, 8'h01);
        check("async_reset_led", {4'd0, led}, 8'h00);
        ntr_clk = 1'b1;
        ntr_cs1 = 1'b1;
        #10;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
